// File: rtl/noc_pkg.sv
// Shared NoC definitions used by the request and response buffering blocks.
//   REQ_VALID_BIT  : position of the request-valid bit inside a request word
//   NOC_REQ_WIDTH  : default request word width
//   NOC_FIFO_DEPTH : default NoC FIFO depth, common to request and response sides
package noc_pkg;

  localparam int REQ_VALID_BIT  = 0;
  localparam int NOC_REQ_WIDTH  = 16;
  localparam int NOC_FIFO_DEPTH = 8;

endpackage

// File: rtl/noc_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write port, asynchronous read port.
// Storage is not reset; occupancy tracking lives in the owning FIFO.
// Ports:
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module noc_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_req_fifo.sv
// Request injection buffer between a requester and the NoC router port.
// Words are stored verbatim and drained in order through a valid/ready
// handshake with show-ahead output. Overflow attempts set a sticky flag.
// Ports:
//   clk         : clock
//   reset       : synchronous active-high reset
//   write       : push strobe from the requester
//   dataIn      : request word to push
//   full        : occupancy == DEPTH (registered count only)
//   almost_full : occupancy >= DEPTH-1 (registered count only)
//   out_data    : head entry, zero when empty
//   out_valid   : FIFO not empty
//   out_ready   : router takes the head entry this cycle
//   count       : current occupancy
//   overflow    : sticky, set when a push is dropped
module noc_req_fifo
  import noc_pkg::*;
#(
  parameter int WIDTH = NOC_REQ_WIDTH,
  parameter int DEPTH = NOC_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write,
  input  logic [WIDTH-1:0] dataIn,
  output logic             full,
  output logic             almost_full,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PTR_W:0]   count,
  output logic             overflow
);

  localparam logic [PTR_W:0] CNT_FULL   = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ALMOST = (PTR_W+1)'(DEPTH - 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             pop;
  logic             push_ok;

  // Flags come from the registered count only so the requester's blocking
  // rule sees a stable value for the whole cycle.
  assign full        = (count == CNT_FULL);
  assign almost_full = (count >= CNT_ALMOST);
  assign out_valid   = (count != '0);

  assign pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok = write & (~full | pop);

  // Empty FIFO presents zero rather than a stale word.
  assign out_data = out_valid ? rd_data : '0;

  noc_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (write & full & ~pop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_noc_req_fifo.sv
module tb_noc_req_fifo;

  localparam int W = 16;
  localparam int D = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic [W-1:0]  dataIn;
  logic          out_ready;
  logic          full;
  logic          almost_full;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic [3:0]    count;
  logic          overflow;

  noc_req_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .dataIn      (dataIn),
    .full        (full),
    .almost_full (almost_full),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  // Reference model: an ordered queue of stored words plus a sticky flag.
  logic [W-1:0] q[$];
  bit           m_ovf;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [15:0] din;
    bit          rdy;
    int          e_cnt;
    bit          e_valid;
    logic [15:0] e_data;
    bit          e_full;
    bit          e_af;
    bit          e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input bit rst, input bit wr, input logic [15:0] din, input bit rdy,
                     input int cnt, input bit v, input logic [15:0] dat,
                     input bit f, input bit af, input bit ov);
    vec_t t;
    t.rst = rst; t.wr = wr; t.din = din; t.rdy = rdy;
    t.e_cnt = cnt; t.e_valid = v; t.e_data = dat;
    t.e_full = f; t.e_af = af; t.e_ovf = ov;
    vecs.push_back(t);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".count"},     32'(count),       32'(q.size()));
    chk({tag, ".valid"},     32'(out_valid),   32'(q.size() != 0));
    chk({tag, ".data"},      32'(out_data),    (q.size() != 0) ? 32'(q[0]) : 32'h0);
    chk({tag, ".full"},      32'(full),        32'(q.size() == D));
    chk({tag, ".af"},        32'(almost_full), 32'(q.size() >= D - 1));
    chk({tag, ".overflow"},  32'(overflow),    32'(m_ovf));
  endtask

  // One clock with the inputs currently driven; model advances alongside.
  task automatic cycle(input string tag);
    bit m_pop;
    bit m_push;
    bit m_rst;
    logic [W-1:0] d;
    m_rst  = reset;
    m_pop  = (q.size() != 0) && out_ready;
    m_push = write && ((q.size() < D) || m_pop);
    d      = dataIn;
    @(posedge clk);
    #1;
    if (m_rst) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      else if (write) m_ovf = 1;
    end
    check_model(tag);
  endtask

  // Structural invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (started && reset === 1'b0) begin
      chk("inv.count_le_depth", 32'(count <= 4'(D)), 32'd1);
      chk("inv.empty_iff_invalid", 32'(count == 4'd0), 32'(!out_valid));
    end
  end

  initial begin
    logic [W-1:0] exp_list[$];
    logic [W-1:0] sent[$];
    logic [W-1:0] got[$];
    bit nxt;
    bit want;

    reset = 1; write = 0; dataIn = '0; out_ready = 0;

    // ---------------- directed table ----------------
    add(1, 1, 16'hBEEF, 1, 0, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 1, 16'h0011, 0, 1, 1, 16'h0011, 0, 0, 0);
    add(0, 1, 16'h0023, 0, 2, 1, 16'h0011, 0, 0, 0);
    add(0, 1, 16'h0035, 0, 3, 1, 16'h0011, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 2, 1, 16'h0023, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 1, 1, 16'h0035, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);
    // push+pop while empty: only the push lands; bit0=0 stored verbatim
    add(0, 1, 16'h1230, 1, 1, 1, 16'h1230, 0, 0, 0);
    add(0, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 0, 0);
    for (int i = 0; i < D; i++)
      add(0, 1, 16'hA000 + 16'(i), 0, i + 1, 1, 16'hA000, (i + 1) == D, (i + 1) >= D - 1, 0);
    add(0, 1, 16'hDEAD, 0, 8, 1, 16'hA000, 1, 1, 1);
    add(0, 0, 16'h0000, 0, 8, 1, 16'hA000, 1, 1, 1);
    for (int i = 1; i <= D; i++)
      add(0, 0, 16'h0000, 1, D - i, (D - i) != 0, (i < D) ? 16'hA000 + 16'(i) : 16'h0000,
          0, (D - i) >= D - 1, 1);
    add(1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0);

    foreach (vecs[k]) begin
      reset = vecs[k].rst; write = vecs[k].wr; dataIn = vecs[k].din; out_ready = vecs[k].rdy;
      @(posedge clk);
      #1;
      started = 1;
      chk($sformatf("vec%0d.count", k), 32'(count),       32'(vecs[k].e_cnt));
      chk($sformatf("vec%0d.valid", k), 32'(out_valid),   32'(vecs[k].e_valid));
      chk($sformatf("vec%0d.data", k),  32'(out_data),    32'(vecs[k].e_data));
      chk($sformatf("vec%0d.full", k),  32'(full),        32'(vecs[k].e_full));
      chk($sformatf("vec%0d.af", k),    32'(almost_full), 32'(vecs[k].e_af));
      chk($sformatf("vec%0d.ovf", k),   32'(overflow),    32'(vecs[k].e_ovf));
    end

    // ---------------- full with simultaneous push/pop across wrap ----------------
    reset = 1; write = 0; out_ready = 0; cycle("wrap.rst");
    reset = 0;
    for (int i = 0; i < D; i++) begin
      write = 1; dataIn = 16'hB000 + 16'(i); cycle("wrap.fill");
    end
    for (int i = 0; i < 4; i++) begin
      write = 1; out_ready = 1; dataIn = 16'hC000 + 16'(i); cycle("wrap.pp");
      chk("wrap.count8", 32'(count), 32'd8);
      chk("wrap.no_ovf", 32'(overflow), 32'd0);
    end
    for (int i = 4; i < D; i++) exp_list.push_back(16'hB000 + 16'(i));
    for (int i = 0; i < 4; i++) exp_list.push_back(16'hC000 + 16'(i));
    write = 0; out_ready = 1;
    foreach (exp_list[k]) begin
      chk($sformatf("wrap.order%0d", k), 32'(out_data), 32'(exp_list[k]));
      cycle("wrap.drain");
    end
    chk("wrap.empty", 32'(out_valid), 32'd0);

    // ---------------- requester-rule random stream ----------------
    reset = 1; write = 0; out_ready = 0; cycle("rnd.rst");
    reset = 0;
    for (int n = 0; n < 1000; n++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      dataIn    = W'($urandom);
      if (write) sent.push_back(dataIn);
      if (out_valid && out_ready) got.push_back(out_data);
      want = ($urandom_range(0, 3) != 0);
      nxt  = want && !((write && almost_full) || (!write && full));
      cycle("rnd");
      write = nxt;
    end
    for (int n = 0; n < 12; n++) begin
      if (write) sent.push_back(dataIn);
      out_ready = 1;
      if (out_valid && out_ready) got.push_back(out_data);
      cycle("rnd.drain");
      write = 0;
    end
    chk("rnd.overflow", 32'(overflow), 32'd0);
    chk("rnd.stream_len", 32'(got.size()), 32'(sent.size()));
    for (int k = 0; k < sent.size() && k < got.size(); k++) begin
      if (got[k] !== sent[k]) begin
        chk($sformatf("rnd.stream%0d", k), 32'(got[k]), 32'(sent[k]));
        break;
      end
    end
    chk("rnd.stream_nonempty", 32'(sent.size() > 100), 32'd1);

    // ---------------- reset mid-stream ----------------
    out_ready = 0;
    for (int i = 0; i < D + 1; i++) begin
      write = 1; dataIn = 16'hE000 + 16'(i); cycle("mid.fill");
    end
    chk("mid.ovf_set", 32'(overflow), 32'd1);
    write = 0; out_ready = 1;
    for (int i = 0; i < 3; i++) cycle("mid.pop");
    chk("mid.count5", 32'(count), 32'd5);
    reset = 1; write = 1; out_ready = 1; dataIn = 16'hFFFF; cycle("mid.rst");
    chk("mid.rst_count", 32'(count), 32'd0);
    chk("mid.rst_valid", 32'(out_valid), 32'd0);
    chk("mid.rst_ovf", 32'(overflow), 32'd0);
    chk("mid.rst_data", 32'(out_data), 32'd0);
    reset = 0; write = 1; out_ready = 0; dataIn = 16'h5A5B; cycle("mid.push");
    chk("mid.readback", 32'(out_data), 32'h5A5B);
    chk("mid.count1", 32'(count), 32'd1);
    write = 0; out_ready = 1; cycle("mid.pop_last");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/noc_req_fifo.md
Name: noc_req_fifo

Overview:
Request injection buffer that sits directly downstream of each requester and feeds the NoC request router port. It accepts one request word per cycle from the requester's write/dataOut pair and reports full/almost_full back with the timing the requester relies on. It drains in order to the router through a valid/ready handshake. Overflow attempts are recorded in a sticky flag for debug.

Parameters:
WIDTH, 16, request word width; bit 0 is the request-valid bit and is carried through unmodified.
DEPTH, 8, number of entries; must be a power of 2 and at least 2.
PTR_W, $clog2(DEPTH), read/write pointer width (derived, not overridden).

Ports:
clk  input  1  single clock for the block.
reset  input  1  synchronous, active-high reset.
write  input  1  push strobe from the requester.
dataIn  input  WIDTH  request word from the requester's dataOut.
full  output  1  asserted when count == DEPTH.
almost_full  output  1  asserted when count >= DEPTH-1.
out_data  output  WIDTH  head entry, presented to the router.
out_valid  output  1  asserted when the FIFO is not empty.
out_ready  input  1  router accepts the head entry this cycle.
count  output  PTR_W+1  current occupancy.
overflow  output  1  sticky; set when a push is dropped.

Behaviour:
- Synchronous reset on the rising edge of clk with reset=1:
  - wr_ptr=0, rd_ptr=0, count=0, overflow=0.
  - Outputs after reset: full=0, almost_full=0, out_valid=0, out_data=0.
  - Storage contents are don't-care.
  - Reset takes priority over a push or pop in the same cycle; in-flight entries are discarded.
- full and almost_full are combinational from the registered count only. They never depend on the current-cycle write or out_ready.
  - This guarantees the requester's rule (block when write&almost_full or ~write&full) never produces a push into a full FIFO.
- pop = out_valid & out_ready.
- push_ok = write & (~full | pop).
  - A push into a full FIFO is accepted when a pop happens in the same cycle; count stays at DEPTH.
- Push: mem[wr_ptr] <= dataIn, wr_ptr <= wr_ptr+1. Pointer wraps modulo DEPTH through natural PTR_W overflow.
- Pop: rd_ptr <= rd_ptr+1, with the same wrap rule.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both or neither: unchanged.
- Show-ahead read: out_data = mem[rd_ptr], combinational.
  - out_data is forced to 0 when empty, so the router never sees stale request words.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N (zero bubble). There is no write-to-read bypass when empty; the entry appears the cycle after the push.
- Simultaneous push and pop when empty: only the push takes effect, because pop requires out_valid. count becomes 1.
- Overflow: write & full & ~pop drops the word, sets overflow=1, and leaves pointers and count unchanged. overflow clears only on reset.
- Data bit 0 is not inspected. The FIFO stores words verbatim, including words with bit0=0 if written.
- out_data must hold stable while out_valid=1 and out_ready=0.
- Assertions in the bench:
  - count never exceeds DEPTH.
  - count == 0 exactly when out_valid == 0.

Decomposition:
- Shared package (noc_pkg):
  - REQ_VALID_BIT = 0.
  - Default request WIDTH.
  - Default NoC FIFO DEPTH, shared with the response-side FIFO.
- One natural sub-module: noc_fifo_mem. It is a DEPTH x WIDTH register array with a synchronous write port and an asynchronous read port, reusable by the response path. Pointer, count and flag logic stay in noc_req_fifo.

Test Plan:
- Reset then idle (write=0, out_ready=0) for 5 cycles -> count=0, out_valid=0, out_data=0, full=0, almost_full=0, overflow=0.
- Push 0x0011, 0x0023, 0x0035 on consecutive cycles with out_ready=0, then assert out_ready -> out_data sequence 0x0011, 0x0023, 0x0035 on consecutive cycles; count goes 3,2,1,0; out_valid drops after the third pop.
- Fill with DEPTH=8 words, out_ready=0 -> almost_full rises when count=7, full rises when count=8; a 9th write sets overflow=1, count stays 8, and the dropped word never appears on out_data.
- Hold the FIFO full, then write=1 and out_ready=1 together for 4 cycles -> 4 pops and 4 pushes accepted, count stays 8, overflow stays 0, output order preserved across the pointer wrap.
- Requester-rule check: drive write per the rule ~((write&almost_full)|(~write&full)) with random out_ready for 1000 cycles -> overflow never sets, and the output stream equals the input stream.
- Assert reset mid-stream with count=5 and push/pop active in the same cycle -> next cycle count=0, out_valid=0, pointers 0, overflow cleared; a push after reset is read back correctly.
